// File: rtl/led_sweep_pkg.sv
// Shared encodings for the LED truth-table sweep controller.
package led_sweep_pkg;

  localparam int unsigned SW_W      = 3;
  localparam int unsigned NUM_CODES = 8;

  localparam logic [SW_W-1:0] LAST_CODE = SW_W'(NUM_CODES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/led_sweep_timer.sv
// Dwell down-counter: load has priority over decrement; stops at zero.
module led_sweep_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/led_sweep_ctrl.sv
// Steps sw_out through all codes, holding each dwell+1 cycles; optional truth-table
// capture of led_in is enabled by defining LED_SWEEP_CAPTURE_EN.
module led_sweep_ctrl
  import led_sweep_pkg::*;
#(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SW_W-1:0]    sw_out,
  input  logic               led_in,
  output logic               busy,
  output logic               done,
  output logic [7:0]         truth,
  output logic               truth_valid
);

  state_e              state_q, state_d;
  logic [SW_W-1:0]     sw_q, sw_d;
  logic                mode_q, mode_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;

  logic                tmr_load, tmr_dec, tmr_zero;
  logic [DWELL_W-1:0]  tmr_val;
  logic                cap_en, cap_clr, cap_valid;

  led_sweep_timer #(
    .W (DWELL_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    sw_d      = sw_q;
    mode_d    = mode_q;
    dwell_d   = dwell_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_val   = dwell_q;
    cap_en    = 1'b0;
    cap_clr   = 1'b0;
    cap_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d  = StRun;
          sw_d     = '0;
          mode_d   = mode;
          dwell_d  = dwell;
          tmr_load = 1'b1;
          tmr_val  = dwell;
          cap_clr  = 1'b1;
        end
      end
      StRun: begin
        if (stop) begin
          state_d  = StIdle;
          sw_d     = '0;
          tmr_load = 1'b1;
          tmr_val  = '0;
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          // Last cycle of this code: sample led_in, then advance or finish.
          cap_en = 1'b1;
          if (sw_q != LAST_CODE) begin
            sw_d     = sw_q + SW_W'(1);
            tmr_load = 1'b1;
          end else begin
            cap_valid = 1'b1;
            if (mode_q) begin
              sw_d     = '0;
              tmr_load = 1'b1;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        sw_d    = '0;
      end
      default: begin
        state_d = StIdle;
        sw_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sw_q    <= '0;
      mode_q  <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
    end
  end

  assign sw_out = sw_q;
  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);

`ifdef LED_SWEEP_CAPTURE_EN
  logic [NUM_CODES-1:0] truth_q, truth_d;
  logic                 truth_valid_q, truth_valid_d;

  always_comb begin
    truth_d       = truth_q;
    truth_valid_d = truth_valid_q;
    if (cap_clr) begin
      truth_d       = '0;
      truth_valid_d = 1'b0;
    end
    if (cap_en) begin
      truth_d[sw_q] = led_in;
    end
    if (cap_valid) begin
      truth_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      truth_q       <= '0;
      truth_valid_q <= 1'b0;
    end else begin
      truth_q       <= truth_d;
      truth_valid_q <= truth_valid_d;
    end
  end

  assign truth       = truth_q;
  assign truth_valid = truth_valid_q;
`else
  logic unused_cap;
  assign unused_cap  = ^{led_in, cap_en, cap_clr, cap_valid};
  assign truth       = 8'h00;
  assign truth_valid = 1'b0;
`endif

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Directed bench for led_sweep_ctrl; expectations follow LED_SWEEP_CAPTURE_EN.
module tb_led_sweep_ctrl;

`ifdef LED_SWEEP_CAPTURE_EN
  localparam bit Cap = 1'b1;
`else
  localparam bit Cap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, mode;
  logic [15:0] dwell;
  logic [2:0]  sw_out;
  logic        led_in;
  logic        busy, done;
  logic [7:0]  truth;
  logic        truth_valid;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_truth;
  logic       exp_tv;

  always #5 clk = ~clk;

  // Parity of the switch code, so the captured table should be 8'h96.
  assign led_in = ^sw_out;

  led_sweep_ctrl #(
    .DWELL_W (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .dwell       (dwell),
    .sw_out      (sw_out),
    .led_in      (led_in),
    .busy        (busy),
    .done        (done),
    .truth       (truth),
    .truth_valid (truth_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic m, input int d);
    start = 1'b1;
    mode  = m;
    dwell = 16'(d);
    tick();
    start = 1'b0;
    mode  = 1'b0;
    dwell = 16'hffff;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 1'b0;
    dwell = '0;
    #2;
    checks++;
    if ({sw_out, busy, done, truth, truth_valid} !== 14'd0) begin
      failures++;
      $display("FAIL reset_state got sw=%0d busy=%b done=%b truth=%h tv=%b want all zero",
               sw_out, busy, done, truth, truth_valid);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({sw_out, busy, done} !== 5'd0) begin
      failures++;
      $display("FAIL idle_after_reset got sw=%0d busy=%b done=%b want 0 0 0",
               sw_out, busy, done);
    end
  endtask

  task automatic test_single_dwell0();
    start_sweep(1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sw_out !== 3'(i) || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL d0_step%0d got sw=%0d busy=%b done=%b want sw=%0d busy=1 done=0",
                 i, sw_out, busy, done, i);
      end
      tick();
    end
    exp_truth = Cap ? 8'h96 : 8'h00;
    exp_tv    = Cap;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sw_out !== 3'd7) begin
      failures++;
      $display("FAIL d0_done got done=%b busy=%b sw=%0d want 1 0 7", done, busy, sw_out);
    end
    checks++;
    if (truth !== exp_truth || truth_valid !== exp_tv) begin
      failures++;
      $display("FAIL d0_truth got truth=%h tv=%b want truth=%h tv=%b",
               truth, truth_valid, exp_truth, exp_tv);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sw_out !== 3'd0) begin
      failures++;
      $display("FAIL d0_back_idle got done=%b busy=%b sw=%0d want 0 0 0", done, busy, sw_out);
    end
  endtask

  task automatic test_single_dwell3();
    start_sweep(1'b0, 3);
    checks++;
    if (truth !== 8'h00 || truth_valid !== 1'b0) begin
      failures++;
      $display("FAIL d3_clear_on_start got truth=%h tv=%b want 00 0", truth, truth_valid);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (sw_out !== 3'(i / 4) || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL d3_cycle%0d got sw=%0d busy=%b done=%b want sw=%0d busy=1 done=0",
                 i, sw_out, busy, done, i / 4);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || truth !== (Cap ? 8'h96 : 8'h00) || truth_valid !== Cap) begin
      failures++;
      $display("FAIL d3_done got done=%b truth=%h tv=%b want done=1 truth=%h tv=%b",
               done, truth, truth_valid, Cap ? 8'h96 : 8'h00, Cap);
    end
    tick();
  endtask

  task automatic test_continuous();
    start_sweep(1'b1, 1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (sw_out !== 3'(i / 2) || busy !== 1'b1 || done !== 1'b0 || truth_valid !== 1'b0) begin
        failures++;
        $display("FAIL cont_pass1_c%0d got sw=%0d busy=%b done=%b tv=%b want sw=%0d 1 0 0",
                 i, sw_out, busy, done, truth_valid, i / 2);
      end
      tick();
    end
    for (int i = 16; i < 27; i++) begin
      checks++;
      if (sw_out !== 3'((i - 16) / 2) || busy !== 1'b1 || done !== 1'b0 || truth_valid !== Cap) begin
        failures++;
        $display("FAIL cont_pass2_c%0d got sw=%0d busy=%b done=%b tv=%b want sw=%0d 1 0 %b",
                 i, sw_out, busy, done, truth_valid, (i - 16) / 2, Cap);
      end
      if (i < 26) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || sw_out !== 3'd0 || done !== 1'b0 || truth_valid !== Cap) begin
      failures++;
      $display("FAIL cont_stop got busy=%b sw=%0d done=%b tv=%b want 0 0 0 %b",
               busy, sw_out, done, truth_valid, Cap);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL cont_stop_no_done got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_start_stop();
    start = 1'b1;
    stop  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || sw_out !== 3'd0 || done !== 1'b0) begin
        failures++;
        $display("FAIL start_stop_c%0d got busy=%b sw=%0d done=%b want 0 0 0",
                 i, busy, sw_out, done);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_start_in_run();
    start_sweep(1'b0, 0);
    start = 1'b1;
    mode  = 1'b1;
    dwell = 16'd5;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sw_out !== 3'(i) || busy !== 1'b1) begin
        failures++;
        $display("FAIL restart_c%0d got sw=%0d busy=%b want sw=%0d busy=1", i, sw_out, busy, i);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL restart_done got done=%b want 1", done);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sw_out !== 3'd0) begin
      failures++;
      $display("FAIL restart_idle got busy=%b done=%b sw=%0d want 0 0 0", busy, done, sw_out);
    end
  endtask

  task automatic test_reset_mid_run();
    start_sweep(1'b0, 1);
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (sw_out !== 3'd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre got sw=%0d busy=%b want 3 1", sw_out, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sw_out !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || truth !== 8'h00
        || truth_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async got sw=%0d busy=%b done=%b truth=%h tv=%b want all zero",
               sw_out, busy, done, truth, truth_valid);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || sw_out !== 3'd0) begin
        checks++;
        failures++;
        $display("FAIL midrst_resume c%0d got busy=%b done=%b sw=%0d want 0 0 0",
                 i, busy, done, sw_out);
      end
    end
    checks++;
    if (busy !== 1'b0 || sw_out !== 3'd0) begin
      failures++;
      $display("FAIL midrst_idle got busy=%b sw=%0d want 0 0", busy, sw_out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_dwell0();
    test_single_dwell3();
    test_continuous();
    test_start_stop();
    test_start_in_run();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
